// File: rtl/fifo_pkt_pkg.sv
// Shared constants and state encodings for the FIFO page sender.
package fifo_pkt_pkg;

  localparam int unsigned BUF_AW   = 13;
  localparam logic [7:0]  HDR_BOOT = 8'hA5;
  localparam logic [7:0]  HDR_USER = 8'h5A;

  typedef enum logic [2:0] {
    StIdle, StHdr, StPgh, StPgl, StFetch, StSend, StCsum, StDone
  } state_e;

  typedef enum logic [1:0] {
    PhWait, PhLow, PhHigh
  } phase_e;

endpackage

// File: rtl/fifo_bitbuf_ram.sv
// 8192x1 simple dual-port bit buffer; registered read, read-before-write on collision.
module fifo_bitbuf_ram
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned AW = BUF_AW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem [1<<AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fifo_page_sender.sv
// Captures emucore page bits and streams them as framed packets into the FT232 async FIFO.
module fifo_page_sender
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned BOOT_BYTES = 64,
  parameter int unsigned USER_BYTES = 64,
  parameter int unsigned WR_LOW     = 4,
  parameter int unsigned WR_HIGH    = 4
) (
  input  logic        MCLK,
  input  logic        nRST,
  input  logic        nEN,
  input  logic        BITWIDTH4,
  input  logic        nFIFOBUFWRCLKEN,
  input  logic [12:0] FIFOBUFWRADDR,
  input  logic        FIFOBUFWRDATA,
  input  logic        nFIFOSENDBOOT,
  input  logic        nFIFOSENDUSER,
  input  logic [11:0] FIFORELPAGE,
  input  logic        nTXE,
  output logic        nWR,
  output logic [7:0]  DOUT,
  output logic        DOE,
  output logic        nBUSY
);

  localparam logic [15:0] LenBoot  = 16'(BOOT_BYTES);
  localparam logic [15:0] LenUser  = 16'(USER_BYTES);
  localparam logic [15:0] LenUser4 = 16'(2 * USER_BYTES);

  state_e             state_q, state_d;
  phase_e             ph_q, ph_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        len_q, len_d, bcnt_q, bcnt_d;
  logic [BUF_AW-1:0]  rd_addr_q, rd_addr_d;
  logic [7:0]         byte_q, byte_d, csum_q, csum_d, dout_q, dout_d;
  logic [11:0]        page_q, page_d;
  logic               is_boot_q, is_boot_d;
  logic               nwr_q, nwr_d, doe_q, doe_d, nbusy_q, nbusy_d;
  logic               pend_boot_q, pend_boot_d, pend_user_q, pend_user_d;
  logic               boot_s_q, user_s_q;
  logic               boot_fall, user_fall, rd_bit, tx_done;
  logic [7:0]         tx_byte;

  fifo_bitbuf_ram #(
    .AW(BUF_AW)
  ) u_ram (
    .clk_i  (MCLK),
    .we_i   (~nFIFOBUFWRCLKEN),
    .waddr_i(FIFOBUFWRADDR),
    .wdata_i(FIFOBUFWRDATA),
    .raddr_i(rd_addr_q),
    .rdata_o(rd_bit)
  );

  assign boot_fall = boot_s_q & ~nFIFOSENDBOOT;
  assign user_fall = user_s_q & ~nFIFOSENDUSER;

  always_comb begin
    tx_byte = byte_q;
    unique case (state_q)
      StHdr:   tx_byte = is_boot_q ? HDR_BOOT : HDR_USER;
      StPgh:   tx_byte = {4'h0, page_q[11:8]};
      StPgl:   tx_byte = page_q[7:0];
      StCsum:  tx_byte = csum_q;
      default: tx_byte = byte_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    bcnt_d      = bcnt_q;
    rd_addr_d   = rd_addr_q;
    byte_d      = byte_q;
    csum_d      = csum_q;
    dout_d      = dout_q;
    page_d      = page_q;
    is_boot_d   = is_boot_q;
    nwr_d       = nwr_q;
    doe_d       = doe_q;
    nbusy_d     = nbusy_q;
    pend_boot_d = pend_boot_q | boot_fall;
    pend_user_d = pend_user_q | user_fall;
    tx_done     = 1'b0;

    // Shared byte handshake for every byte-emitting state.
    if (state_q inside {StHdr, StPgh, StPgl, StSend, StCsum}) begin
      unique case (ph_q)
        PhWait: if (!nTXE) begin
          dout_d = tx_byte;
          ph_d   = PhLow;
          cnt_d  = 8'd0;
          if (state_q == StSend) csum_d = csum_q + byte_q;
        end
        PhLow: begin
          nwr_d = 1'b0;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(WR_LOW - 1)) begin
            ph_d  = PhHigh;
            cnt_d = 8'd0;
          end
        end
        PhHigh: begin
          nwr_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(WR_HIGH - 1)) begin
            ph_d    = PhWait;
            cnt_d   = 8'd0;
            tx_done = 1'b1;
          end
        end
        default: ph_d = PhWait;
      endcase
    end

    unique case (state_q)
      StIdle: if (!nEN && (pend_boot_q || pend_user_q)) begin
        is_boot_d = pend_boot_q;
        // A fresh edge in the acceptance cycle is a new request, so it re-arms the flag.
        if (pend_boot_q) pend_boot_d = boot_fall;
        else             pend_user_d = user_fall;
        len_d     = pend_boot_q ? LenBoot : (BITWIDTH4 ? LenUser4 : LenUser);
        page_d    = FIFORELPAGE;
        rd_addr_d = '0;
        csum_d    = 8'd0;
        bcnt_d    = 16'd0;
        nbusy_d   = 1'b0;
        doe_d     = 1'b1;
        ph_d      = PhWait;
        cnt_d     = 8'd0;
        state_d   = StHdr;
      end
      StHdr: if (tx_done) state_d = StPgh;
      StPgh: if (tx_done) state_d = StPgl;
      StPgl: if (tx_done) state_d = StFetch;
      StFetch: begin
        // Eight reads issued on cnt 0..7, each bit landing one cycle later.
        cnt_d = cnt_q + 8'd1;
        if (cnt_q < 8'd8) rd_addr_d = rd_addr_q + BUF_AW'(1);
        if (cnt_q != 8'd0) byte_d[3'(cnt_q - 8'd1)] = rd_bit;
        if (cnt_q == 8'd8) begin
          state_d = StSend;
          cnt_d   = 8'd0;
          ph_d    = PhWait;
        end
      end
      StSend: if (tx_done) begin
        bcnt_d  = bcnt_q + 16'd1;
        state_d = (bcnt_q + 16'd1 == len_q) ? StCsum : StFetch;
      end
      StCsum: if (tx_done) begin
        state_d = StDone;
        doe_d   = 1'b0;
        nbusy_d = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (nEN) begin
      pend_boot_d = 1'b0;
      pend_user_d = 1'b0;
      if (state_q != StIdle) begin
        state_d = StIdle;
        ph_d    = PhWait;
        cnt_d   = 8'd0;
        nwr_d   = 1'b1;
        doe_d   = 1'b0;
        nbusy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      state_q     <= StIdle;
      ph_q        <= PhWait;
      cnt_q       <= 8'd0;
      len_q       <= 16'd0;
      bcnt_q      <= 16'd0;
      rd_addr_q   <= '0;
      byte_q      <= 8'd0;
      csum_q      <= 8'd0;
      dout_q      <= 8'd0;
      page_q      <= 12'd0;
      is_boot_q   <= 1'b0;
      nwr_q       <= 1'b1;
      doe_q       <= 1'b0;
      nbusy_q     <= 1'b1;
      pend_boot_q <= 1'b0;
      pend_user_q <= 1'b0;
      boot_s_q    <= 1'b1;
      user_s_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      bcnt_q      <= bcnt_d;
      rd_addr_q   <= rd_addr_d;
      byte_q      <= byte_d;
      csum_q      <= csum_d;
      dout_q      <= dout_d;
      page_q      <= page_d;
      is_boot_q   <= is_boot_d;
      nwr_q       <= nwr_d;
      doe_q       <= doe_d;
      nbusy_q     <= nbusy_d;
      pend_boot_q <= pend_boot_d;
      pend_user_q <= pend_user_d;
      boot_s_q    <= nFIFOSENDBOOT;
      user_s_q    <= nFIFOSENDUSER;
    end
  end

  assign nWR   = nwr_q;
  assign DOUT  = dout_q;
  assign DOE   = doe_q;
  assign nBUSY = nbusy_q;

endmodule

// File: tb/tb_fifo_page_sender.sv
// Randomised bench for fifo_page_sender against a packet-level reference model.
module tb_fifo_page_sender;

  localparam int unsigned WR_LOW  = 4;
  localparam int unsigned WR_HIGH = 4;

  logic        MCLK = 1'b0;
  logic        nRST, nEN, BITWIDTH4, nFIFOBUFWRCLKEN, FIFOBUFWRDATA;
  logic        nFIFOSENDBOOT, nFIFOSENDUSER, nTXE, nWR, DOE, nBUSY;
  logic [12:0] FIFOBUFWRADDR;
  logic [11:0] FIFORELPAGE;
  logic [7:0]  DOUT;

  bit txe_hold = 1'b0, txe_rand = 1'b0, rnd_bit = 1'b0;
  assign nTXE = txe_hold | (txe_rand & rnd_bit);

  fifo_page_sender #(
    .BOOT_BYTES(64),
    .USER_BYTES(64),
    .WR_LOW    (WR_LOW),
    .WR_HIGH   (WR_HIGH)
  ) dut (
    .MCLK           (MCLK),
    .nRST           (nRST),
    .nEN            (nEN),
    .BITWIDTH4      (BITWIDTH4),
    .nFIFOBUFWRCLKEN(nFIFOBUFWRCLKEN),
    .FIFOBUFWRADDR  (FIFOBUFWRADDR),
    .FIFOBUFWRDATA  (FIFOBUFWRDATA),
    .nFIFOSENDBOOT  (nFIFOSENDBOOT),
    .nFIFOSENDUSER  (nFIFOSENDUSER),
    .FIFORELPAGE    (FIFORELPAGE),
    .nTXE           (nTXE),
    .nWR            (nWR),
    .DOUT           (DOUT),
    .DOE            (DOE),
    .nBUSY          (nBUSY)
  );

  initial forever #5 MCLK = ~MCLK;

  int         n_tests = 0, n_fail = 0;
  bit         mem_m [8192];
  logic [7:0] rx[$], exp_q[$];
  int         bad_width = 0, bad_hold = 0, rises = 0;
  logic       prev_nwr = 1'b1;
  logic [7:0] prev_dout = 8'd0, fall_byte = 8'd0;
  int         low_cnt = 0, since_rise = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: a byte counts when nWR rises with DOE still high.
  initial forever begin
    @(negedge MCLK);
    if (!nWR) begin
      if (prev_nwr) begin
        fall_byte = DOUT;
        if (DOE && DOUT !== prev_dout) bad_hold++;
      end else if (DOUT !== fall_byte) bad_hold++;
      low_cnt++;
      since_rise = 0;
    end else begin
      if (!prev_nwr) begin
        rises++;
        if (DOE) begin
          rx.push_back(fall_byte);
          if (low_cnt != WR_LOW) bad_width++;
          since_rise = 1;
        end
        low_cnt = 0;
      end
      if (since_rise > 0) begin
        if (DOE && DOUT !== fall_byte) bad_hold++;
        since_rise = (since_rise >= WR_HIGH) ? 0 : since_rise + 1;
      end
    end
    prev_nwr  = nWR;
    prev_dout = DOUT;
  end

  initial forever begin
    @(negedge MCLK);
    rnd_bit = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic wr_bit(input int a, input bit v);
    @(negedge MCLK);
    nFIFOBUFWRCLKEN = 1'b0;
    FIFOBUFWRADDR   = 13'(a);
    FIFOBUFWRDATA   = v;
    mem_m[a]        = v;
  endtask

  task automatic wr_end();
    @(negedge MCLK);
    nFIFOBUFWRCLKEN = 1'b1;
  endtask

  task automatic send_req(input bit boot, input bit user);
    @(negedge MCLK);
    if (boot) nFIFOSENDBOOT = 1'b0;
    if (user) nFIFOSENDUSER = 1'b0;
    @(negedge MCLK);
    nFIFOSENDBOOT = 1'b1;
    nFIFOSENDUSER = 1'b1;
  endtask

  // Reference packet: header, page, LSB-first payload from the model buffer, mod-256 sum.
  task automatic expect_pkt(input bit boot, input bit bw4, input logic [11:0] page);
    int         len = boot ? 64 : (bw4 ? 128 : 64);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    exp_q.push_back(boot ? 8'hA5 : 8'h5A);
    exp_q.push_back({4'h0, page[11:8]});
    exp_q.push_back(page[7:0]);
    for (int k = 0; k < len; k++) begin
      b = 8'd0;
      for (int i = 0; i < 8; i++) if (mem_m[8*k+i]) b = b + 8'(1 << i);
      exp_q.push_back(b);
      sum = sum + b;
    end
    exp_q.push_back(sum);
  endtask

  task automatic clear_mon();
    rx.delete();
    exp_q.delete();
    bad_width = 0;
    bad_hold  = 0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int t = 0;
    while (rx.size() < n && t < 20000) begin
      @(negedge MCLK);
      t++;
    end
    if (t >= 20000) check({tag, "_rx_timeout"}, 32'(rx.size()), 32'(n));
  endtask

  task automatic wait_done(input int n, input string tag);
    int t = 0;
    do begin
      @(negedge MCLK);
      t++;
    end while (!(rx.size() >= n && nBUSY) && t < 30000);
    if (t >= 30000) check({tag, "_done_timeout"}, 32'(rx.size()), 32'(n));
  endtask

  task automatic compare(input string tag);
    int nbad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx.size() || rx[i] !== exp_q[i]) nbad++;
    check({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
    check({tag, "_bad_bytes"}, 32'(nbad), 32'd0);
    check({tag, "_nwr_width"}, 32'(bad_width), 32'd0);
    check({tag, "_dout_hold"}, 32'(bad_hold), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_nwr"}, 32'(nWR), 32'd1);
    check({tag, "_dout"}, 32'(DOUT), 32'd0);
    check({tag, "_doe"}, 32'(DOE), 32'd0);
    check({tag, "_nbusy"}, 32'(nBUSY), 32'd1);
  endtask

  initial begin
    logic [11:0] page;
    logic [7:0]  d0;
    int          lows, chg, r0, busy_low;
    bit          boot;

    nRST = 1'b0; nEN = 1'b0; BITWIDTH4 = 1'b0; nFIFOBUFWRCLKEN = 1'b1;
    FIFOBUFWRADDR = '0; FIFOBUFWRDATA = 1'b0; nFIFOSENDBOOT = 1'b1; nFIFOSENDUSER = 1'b1;
    FIFORELPAGE = '0;
    tick(3);
    check_reset_outs("reset");
    nRST = 1'b1;
    tick(2);

    // Boot packet of alternating bits.
    for (int i = 0; i < 512; i++) wr_bit(i, bit'(i & 1));
    wr_end();
    FIFORELPAGE = 12'h123;
    clear_mon();
    expect_pkt(1'b1, 1'b0, 12'h123);
    send_req(1'b1, 1'b0);
    wait_done(68, "boot");
    compare("boot");
    check("boot_hdr", 32'(rx.size() > 2 ? {rx[0], rx[1], rx[2]} : 24'd0), 32'hA50123);
    check("boot_payload", 32'(rx.size() > 3 ? rx[3] : 8'd0), 32'hAA);
    check("boot_csum", 32'(rx.size() == 68 ? rx[67] : 8'd0), 32'h80);

    // Wide user packet from an all-ones buffer.
    for (int i = 0; i < 1024; i++) wr_bit(i, 1'b1);
    wr_end();
    BITWIDTH4   = 1'b1;
    FIFORELPAGE = 12'hFFF;
    clear_mon();
    expect_pkt(1'b0, 1'b1, 12'hFFF);
    send_req(1'b0, 1'b1);
    wait_done(132, "user4");
    compare("user4");
    check("user4_hdr", 32'(rx.size() > 2 ? {rx[0], rx[1], rx[2]} : 24'd0), 32'h5A0FFF);
    check("user4_csum", 32'(rx.size() == 132 ? rx[131] : 8'd0), 32'h80);

    // Backpressure stall after the tenth byte.
    for (int i = 0; i < 1024; i++) wr_bit(i, bit'($urandom_range(0, 1)));
    wr_end();
    BITWIDTH4   = 1'b0;
    FIFORELPAGE = 12'($urandom);
    page        = FIFORELPAGE;
    clear_mon();
    expect_pkt(1'b1, 1'b0, page);
    send_req(1'b1, 1'b0);
    wait_rx(10, "bp");
    txe_hold = 1'b1;
    d0 = DOUT; lows = 0; chg = 0;
    repeat (50) begin
      @(negedge MCLK);
      if (!nWR) lows++;
      if (DOUT !== d0) chg++;
    end
    check("bp_nwr_low", 32'(lows), 32'd0);
    check("bp_dout_moved", 32'(chg), 32'd0);
    check("bp_rx_frozen", 32'(rx.size()), 32'd10);
    txe_hold = 1'b0;
    wait_done(68, "bp");
    compare("bp");

    // Simultaneous requests plus an absorbed repeat user edge.
    BITWIDTH4   = 1'b1;
    FIFORELPAGE = 12'($urandom);
    page        = FIFORELPAGE;
    clear_mon();
    expect_pkt(1'b1, 1'b1, page);
    expect_pkt(1'b0, 1'b1, page);
    send_req(1'b1, 1'b1);
    wait_rx(5, "dual");
    send_req(1'b0, 1'b1);
    wait_done(200, "dual");
    tick(300);
    compare("dual");

    // Abort during the 20th payload byte with a user request pending.
    BITWIDTH4   = 1'b0;
    FIFORELPAGE = 12'($urandom);
    page        = FIFORELPAGE;
    clear_mon();
    expect_pkt(1'b0, 1'b0, page);
    while (exp_q.size() > 22) void'(exp_q.pop_back());
    send_req(1'b0, 1'b1);
    wait_rx(5, "abort");
    send_req(1'b0, 1'b1);
    wait_rx(22, "abort");
    begin
      int t = 0;
      while (nWR && t < 2000) begin
        @(negedge MCLK);
        t++;
      end
      check("abort_nwr_fell", 32'(nWR), 32'd0);
    end
    nEN = 1'b1;
    @(negedge MCLK);
    check("abort_nwr", 32'(nWR), 32'd1);
    check("abort_doe", 32'(DOE), 32'd0);
    check("abort_nbusy", 32'(nBUSY), 32'd1);
    r0 = rises;
    tick(3);
    nEN = 1'b0;
    busy_low = 0;
    repeat (400) begin
      @(negedge MCLK);
      if (!nBUSY) busy_low++;
    end
    check("abort_no_pulses", 32'(rises), 32'(r0));
    check("abort_pending_dropped", 32'(busy_low), 32'd0);
    compare("abort");

    // Reset mid-packet, then a clean packet.
    BITWIDTH4 = 1'b1;
    clear_mon();
    send_req(1'b1, 1'b0);
    wait_rx(6, "rst");
    nRST = 1'b0;
    @(negedge MCLK);
    check_reset_outs("rst_mid");
    nRST = 1'b1;
    tick(5);
    FIFORELPAGE = 12'($urandom);
    page        = FIFORELPAGE;
    clear_mon();
    expect_pkt(1'b1, 1'b1, page);
    send_req(1'b1, 1'b0);
    wait_done(68, "rst");
    compare("rst");

    // Random packets with random backpressure.
    for (int it = 0; it < 6; it++) begin
      repeat (150) wr_bit(int'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)));
      wr_end();
      boot        = bit'($urandom_range(0, 1));
      BITWIDTH4   = 1'($urandom_range(0, 1));
      FIFORELPAGE = 12'($urandom);
      page        = FIFORELPAGE;
      clear_mon();
      expect_pkt(boot, BITWIDTH4, page);
      txe_rand = 1'b1;
      send_req(boot, !boot);
      wait_done(exp_q.size(), "rnd");
      txe_rand = 1'b0;
      compare("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
